tmr_evt_arbiter: RTL and testbench
==================================

Name: tmr_evt_arbiter

Overview:
- Collects single-cycle match0/match1/ovf event pulses from the timer instances.
- Latches each pulse into a per-source pending flag and tracks overruns.
- Arbitrates the pending, enabled sources round-robin into one interrupt request with a source ID, held until acknowledged.
- Sits between the timer blocks and the core interrupt input.

Parameters:
- NUM_SRC, 6, number of event sources (2 timers x {match0, match1, ovf}); legal range 2..32.
- ID_WIDTH, 3, width of irq_id; must satisfy 2^ID_WIDTH >= NUM_SRC.

Ports:
- sys_clk  input  1  system clock; only clock of the block.
- sys_rst_n  input  1  asynchronous active-low reset.
- evt_in  input  NUM_SRC  event pulses, one sys_clk wide, synchronous to sys_clk.
- evt_en  input  NUM_SRC  per-source interrupt enable (from ctrl SFR).
- pend_clr  input  NUM_SRC  software clear of pending flags, one-cycle pulse.
- ovrn_clr  input  NUM_SRC  software clear of overrun flags, one-cycle pulse.
- irq_ack  input  1  core acknowledge, one-cycle pulse.
- irq_req  output  1  interrupt request, registered.
- irq_id  output  ID_WIDTH  index of requesting source, registered.
- pend  output  NUM_SRC  pending flags, registered.
- ovrn  output  NUM_SRC  sticky overrun flags, registered.

Behaviour:
- Reset (async, sys_rst_n=0):
  - pend=0, ovrn=0, irq_req=0, irq_id=0.
  - rr_ptr=0; state=IDLE.
- Pending update per bit i, priority high to low:
  - evt_in[i]=1 -> pend[i]=1 (set wins over pend_clr and over ack-clear).
  - pend_clr[i]=1 -> pend[i]=0.
  - ack-clear of i (REQ state, irq_ack=1, irq_id=i) -> pend[i]=0.
  - otherwise pend[i] holds.
- Masking: pend latches regardless of evt_en; only pend&evt_en is eligible for arbitration.
- Overrun:
  - evt_in[i]=1 while pend[i]=1 and pend[i] is not being cleared that cycle -> ovrn[i]=1 next cycle.
  - ovrn_clr[i] clears ovrn[i]; a simultaneous set wins over the clear.
  - ovrn never affects arbitration.
- Arbitration:
  - Round-robin over eligible = pend & evt_en.
  - Search starts at rr_ptr, ascends and wraps modulo NUM_SRC.
  - First eligible index wins.
- FSM states: IDLE, REQ, GAP.
- IDLE:
  - If eligible != 0: register winner into irq_id, irq_req=1 next cycle, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - irq_req=1 and irq_id is stable.
  - irq_ack=1 -> clear pend[irq_id], rr_ptr=(irq_id+1) mod NUM_SRC, irq_req=0 next cycle, go to GAP.
  - Withdraw: if eligible[irq_id]=0 (sw clear or enable drop) and irq_ack=0, then irq_req=0 next cycle, go to IDLE, rr_ptr unchanged.
  - If ack and withdraw occur in the same cycle, ack wins.
- GAP: one cycle with irq_req=0, guaranteeing a deassert between requests; then go to IDLE.
- Latency:
  - evt_in pulse at cycle t -> pend at t+1 -> irq_req=1 at t+2 (enabled source, IDLE).
  - Back-to-back requests are spaced by at least 2 cycles of irq_req=0 (GAP + IDLE).
- Stray acks: irq_ack outside REQ is ignored, with no state or pointer change.
- irq_id holds its last value while irq_req=0.

Test Plan:
- Reset mid-REQ (irq_req=1, pend=6'b000100), assert sys_rst_n=0 -> all outputs 0 immediately; after release, no request until a new event.
- evt_in=6'b000100 at cycle 10, evt_en=6'b111111 -> pend[2]=1 at 11, irq_req=1 with irq_id=2 at 12; irq_ack at 14 -> pend[2]=0 and irq_req=0 at 15, rr_ptr=3.
- pend=6'b100011 (sources 0, 1, 5), all enabled, rr_ptr=0, ack each promptly -> irq_id sequence 0, 1, 5; then evt_in[0] -> next id 0 (wrap-around).
- Request irq_id=3 pending, evt_in[3] pulses again before ack -> ovrn[3]=1; pend[3] stays 1; irq_ack, then the pulse arrives in the same cycle -> pend[3] remains 1 and re-requests after GAP.
- In REQ with irq_id=4, drop evt_en[4]; pend[1] eligible -> irq_req=0 next cycle, pend[4] still 1, then request with irq_id=1 two cycles later.
- evt_en=0, evt_in=6'b111111 -> pend=6'b111111, irq_req stays 0; set evt_en[5]=1 -> irq_id=5 within 2 cycles.

Source files
------------

// File: rtl/tmr_evt_arbiter_if.sv
// Event/interrupt bundle between the timer blocks, the ctrl SFRs and the core
// interrupt input. The arbiter takes the slave side.
interface tmr_evt_arbiter_if #(
    parameter int NUM_SRC  = 6,
    parameter int ID_WIDTH = 3
);
    logic [NUM_SRC-1:0]  evt_in;
    logic [NUM_SRC-1:0]  evt_en;
    logic [NUM_SRC-1:0]  pend_clr;
    logic [NUM_SRC-1:0]  ovrn_clr;
    logic                irq_ack;
    logic                irq_req;
    logic [ID_WIDTH-1:0] irq_id;
    logic [NUM_SRC-1:0]  pend;
    logic [NUM_SRC-1:0]  ovrn;

    modport slave (
        input  evt_in, evt_en, pend_clr, ovrn_clr, irq_ack,
        output irq_req, irq_id, pend, ovrn
    );

    modport master (
        output evt_in, evt_en, pend_clr, ovrn_clr, irq_ack,
        input  irq_req, irq_id, pend, ovrn
    );
endinterface

// File: rtl/tmr_evt_arbiter.sv
// Timer event collector: per-source pending/overrun flags plus a round-robin
// arbiter that presents one held interrupt request with its source ID.

// One source's pending and sticky overrun flag; a new event beats any clear.
module tmr_evt_flag (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_evt,
    input  logic i_pend_clr,
    input  logic i_ovrn_clr,
    output logic o_pend,
    output logic o_ovrn
);
    logic r_pend;
    logic r_ovrn;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pend <= 1'b0;
            r_ovrn <= 1'b0;
        end else begin
            if (i_evt)
                r_pend <= 1'b1;
            else if (i_pend_clr)
                r_pend <= 1'b0;
            // A repeat event only counts as lost if the earlier one is still unserviced.
            if (i_evt && r_pend && !i_pend_clr)
                r_ovrn <= 1'b1;
            else if (i_ovrn_clr)
                r_ovrn <= 1'b0;
        end
    end

    assign o_pend = r_pend;
    assign o_ovrn = r_ovrn;
endmodule

module tmr_evt_arbiter #(
    parameter int NUM_SRC  = 6,
    parameter int ID_WIDTH = 3
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    tmr_evt_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_WIDTH-1:0] r_rr_ptr;
    logic [ID_WIDTH-1:0] w_rr_nxt;
    logic [ID_WIDTH-1:0] r_irq_id;
    logic [ID_WIDTH-1:0] w_id_nxt;
    logic                r_irq_req;

    logic [NUM_SRC-1:0]  w_pend;
    logic [NUM_SRC-1:0]  w_ovrn;
    logic [NUM_SRC-1:0]  w_elig;
    logic [NUM_SRC-1:0]  w_id_mask;
    logic [NUM_SRC-1:0]  w_ack_clr;
    logic                w_ack_hit;
    logic                w_id_elig;
    logic                w_win_vld;
    logic [ID_WIDTH-1:0] w_win_id;
    logic [ID_WIDTH:0]   w_idx;

    assign w_elig    = w_pend & bus.evt_en;
    assign w_id_mask = NUM_SRC'(1) << r_irq_id;
    assign w_ack_hit = (r_state == ST_REQ) && bus.irq_ack;
    assign w_ack_clr = w_ack_hit ? w_id_mask : '0;
    assign w_id_elig = |(w_elig & w_id_mask);

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        tmr_evt_flag u_flag (
            .sys_clk    (sys_clk),
            .sys_rst_n  (sys_rst_n),
            .i_evt      (bus.evt_in[g]),
            .i_pend_clr (bus.pend_clr[g] | w_ack_clr[g]),
            .i_ovrn_clr (bus.ovrn_clr[g]),
            .o_pend     (w_pend[g]),
            .o_ovrn     (w_ovrn[g])
        );
    end

    // Round-robin search: walk upward from r_rr_ptr, wrapping at NUM_SRC.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_id  = '0;
        w_idx     = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (ID_WIDTH+1)'(k);
            if (w_idx >= (ID_WIDTH+1)'(NUM_SRC))
                w_idx = w_idx - (ID_WIDTH+1)'(NUM_SRC);
            if (!w_win_vld && |(w_elig & (NUM_SRC'(1) << w_idx))) begin
                w_win_vld = 1'b1;
                w_win_id  = w_idx[ID_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_irq_id;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt = ST_REQ;
                    w_id_nxt    = w_win_id;
                end
            end
            ST_REQ: begin
                // Ack takes precedence over a simultaneous withdraw.
                if (bus.irq_ack) begin
                    w_state_nxt = ST_GAP;
                    w_rr_nxt    = (r_irq_id == ID_WIDTH'(NUM_SRC-1)) ? '0
                                                                   : r_irq_id + ID_WIDTH'(1);
                end else if (!w_id_elig) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= '0;
            r_irq_id  <= '0;
            r_irq_req <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rr_ptr  <= w_rr_nxt;
            r_irq_id  <= w_id_nxt;
            r_irq_req <= (w_state_nxt == ST_REQ);
        end
    end

    assign bus.irq_req = r_irq_req;
    assign bus.irq_id  = r_irq_id;
    assign bus.pend    = w_pend;
    assign bus.ovrn    = w_ovrn;
endmodule

// File: tb/tb_tmr_evt_arbiter.sv
// Randomized and directed bench for tmr_evt_arbiter against a behavioural
// model of the pending/overrun/round-robin rules.
module tb_tmr_evt_arbiter;
    localparam int N  = 6;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tmr_evt_arbiter_if #(.NUM_SRC(N), .ID_WIDTH(IW)) bus ();

    tmr_evt_arbiter #(.NUM_SRC(N), .ID_WIDTH(IW)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [N-1:0] en;
    // model: flags, whether a request is outstanding, whether the gap cycle is running
    logic [N-1:0] m_pend, m_ovrn;
    bit           m_req, m_gap;
    int           m_id, m_rr;

    task automatic model_reset();
        m_pend = '0; m_ovrn = '0; m_req = 0; m_gap = 0; m_id = 0; m_rr = 0;
    endtask

    task automatic model_step(input logic [N-1:0] evt, pclr, oclr, input logic ack);
        logic [N-1:0] pn, on;
        bit clr, found;
        for (int i = 0; i < N; i++) begin
            clr   = pclr[i] || (m_req && ack && m_id == i);
            on[i] = (evt[i] && m_pend[i] && !clr) ? 1'b1 : (oclr[i] ? 1'b0 : m_ovrn[i]);
            pn[i] = evt[i] ? 1'b1 : (clr ? 1'b0 : m_pend[i]);
        end
        if (m_req) begin
            if (ack) begin
                m_req = 0; m_gap = 1; m_rr = (m_id + 1) % N;
            end else if (!(m_pend[m_id] && en[m_id])) begin
                m_req = 0;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_rr + k) % N;
                if (!found && m_pend[j] && en[j]) begin
                    found = 1; m_id = j; m_req = 1;
                end
            end
        end
        m_pend = pn;
        m_ovrn = on;
    endtask

    task automatic cyc(input logic [N-1:0] evt, pclr, oclr, input logic ack);
        bus.evt_in = evt; bus.evt_en = en; bus.pend_clr = pclr;
        bus.ovrn_clr = oclr; bus.irq_ack = ack;
        model_step(evt, pclr, oclr, ack);
        @(posedge clk);
        #1;
        bus.evt_in = '0; bus.pend_clr = '0; bus.ovrn_clr = '0; bus.irq_ack = 1'b0;
    endtask

    task automatic do_reset();
        bus.evt_in = '0; bus.pend_clr = '0; bus.ovrn_clr = '0; bus.irq_ack = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        en = '1; bus.evt_en = en;
        bus.evt_in = '0; bus.pend_clr = '0; bus.ovrn_clr = '0; bus.irq_ack = 1'b0;
        rst_n = 1'b0;
        #3;
        total++; if (bus.irq_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", bus.irq_req); end
        total++; if (bus.irq_id !== 3'd0) begin bad++; $display("FAIL reset_id got=%0d want=0", bus.irq_id); end
        total++; if (bus.pend !== 6'd0) begin bad++; $display("FAIL reset_pend got=%b want=0", bus.pend); end
        total++; if (bus.ovrn !== 6'd0) begin bad++; $display("FAIL reset_ovrn got=%b want=0", bus.ovrn); end
        do_reset();
        // reach REQ on source 2, then pull reset asynchronously mid-cycle
        cyc(6'b000100, '0, '0, 0);
        cyc('0, '0, '0, 0);
        total++; if (bus.irq_req !== 1'b1 || bus.pend !== 6'b000100) begin bad++;
            $display("FAIL midreq_setup req=%b pend=%b want 1/000100", bus.irq_req, bus.pend); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.irq_req !== 1'b0 || bus.irq_id !== 3'd0 || bus.pend !== 6'd0 || bus.ovrn !== 6'd0) begin bad++;
            $display("FAIL midreq_async req=%b id=%0d pend=%b ovrn=%b want all 0", bus.irq_req, bus.irq_id, bus.pend, bus.ovrn); end
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) cyc('0, '0, '0, 0);
        total++; if (bus.irq_req !== 1'b0 || bus.pend !== 6'd0) begin bad++;
            $display("FAIL post_reset_quiet req=%b pend=%b want 0/0", bus.irq_req, bus.pend); end
    endtask

    task automatic test_latency();
        do_reset();
        en = '1;
        cyc(6'b000100, '0, '0, 0);
        total++; if (bus.pend !== 6'b000100 || bus.irq_req !== 1'b0) begin bad++;
            $display("FAIL lat_t1 pend=%b req=%b want 000100/0", bus.pend, bus.irq_req); end
        cyc('0, '0, '0, 0);
        total++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd2) begin bad++;
            $display("FAIL lat_t2 req=%b id=%0d want 1/2", bus.irq_req, bus.irq_id); end
        cyc('0, '0, '0, 0);
        total++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd2) begin bad++;
            $display("FAIL lat_hold req=%b id=%0d want 1/2", bus.irq_req, bus.irq_id); end
        cyc('0, '0, '0, 1);
        total++; if (bus.irq_req !== 1'b0 || bus.pend !== 6'd0 || bus.irq_id !== 3'd2) begin bad++;
            $display("FAIL lat_ack req=%b pend=%b id=%0d want 0/0/2", bus.irq_req, bus.pend, bus.irq_id); end
        // stray ack during the gap must not move anything
        cyc('0, '0, '0, 1);
        // pointer now at 3: of sources 0 and 4, source 4 goes first
        cyc(6'b010001, '0, '0, 0);
        cyc('0, '0, '0, 0);
        total++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd4) begin bad++;
            $display("FAIL rr_after_ack req=%b id=%0d want 1/4", bus.irq_req, bus.irq_id); end
    endtask

    task automatic test_round_robin();
        int exp_ids[4] = '{0, 1, 5, 0};
        int zeros;
        do_reset();
        en = '1;
        cyc(6'b100011, '0, '0, 0);
        for (int n = 0; n < 4; n++) begin
            if (n == 3) cyc(6'b000001, '0, '0, 0);
            zeros = 0;
            for (int k = 0; k < 8 && bus.irq_req !== 1'b1; k++) begin
                cyc('0, '0, '0, 0);
                zeros++;
            end
            total++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'(exp_ids[n])) begin bad++;
                $display("FAIL rr_seq%0d req=%b id=%0d want 1/%0d", n, bus.irq_req, bus.irq_id, exp_ids[n]); end
            if (n == 1 || n == 2) begin
                total++; if (zeros < 2) begin bad++;
                    $display("FAIL rr_gap%0d idle_cycles=%0d want>=2", n, zeros); end
            end
            cyc('0, '0, '0, 1);
        end
        total++; if (bus.pend !== 6'd0 || bus.irq_req !== 1'b0) begin bad++;
            $display("FAIL rr_drain pend=%b req=%b want 0/0", bus.pend, bus.irq_req); end
    endtask

    task automatic test_overrun();
        do_reset();
        en = '1;
        cyc(6'b001000, '0, '0, 0);
        cyc('0, '0, '0, 0);
        cyc(6'b001000, '0, '0, 0);
        total++; if (bus.ovrn !== 6'b001000 || bus.pend !== 6'b001000 || bus.irq_req !== 1'b1 || bus.irq_id !== 3'd3) begin bad++;
            $display("FAIL ovrn_set ovrn=%b pend=%b req=%b id=%0d want 001000/001000/1/3", bus.ovrn, bus.pend, bus.irq_req, bus.irq_id); end
        cyc(6'b001000, '0, '0, 1);
        total++; if (bus.pend !== 6'b001000 || bus.irq_req !== 1'b0) begin bad++;
            $display("FAIL ack_vs_evt pend=%b req=%b want 001000/0", bus.pend, bus.irq_req); end
        cyc('0, '0, '0, 0);
        cyc('0, '0, '0, 0);
        total++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd3) begin bad++;
            $display("FAIL rereq req=%b id=%0d want 1/3", bus.irq_req, bus.irq_id); end
        cyc('0, '0, 6'b001000, 0);
        total++; if (bus.ovrn !== 6'd0) begin bad++; $display("FAIL ovrn_clr ovrn=%b want 0", bus.ovrn); end
        cyc(6'b001000, '0, 6'b001000, 0);
        total++; if (bus.ovrn !== 6'b001000) begin bad++; $display("FAIL ovrn_set_wins ovrn=%b want 001000", bus.ovrn); end
        // event with a same-cycle software clear: no overrun, pend stays set
        cyc('0, '0, 6'b001000, 0);
        cyc(6'b001000, 6'b001000, '0, 0);
        total++; if (bus.ovrn !== 6'd0 || bus.pend !== 6'b001000) begin bad++;
            $display("FAIL evt_vs_clr ovrn=%b pend=%b want 0/001000", bus.ovrn, bus.pend); end
    endtask

    task automatic test_withdraw();
        do_reset();
        en = '1;
        cyc(6'b010000, '0, '0, 0);
        cyc('0, '0, '0, 0);
        cyc(6'b000010, '0, '0, 0);
        total++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd4) begin bad++;
            $display("FAIL wd_setup req=%b id=%0d want 1/4", bus.irq_req, bus.irq_id); end
        en = 6'b101111;
        cyc('0, '0, '0, 0);
        total++; if (bus.irq_req !== 1'b0 || bus.pend !== 6'b010010) begin bad++;
            $display("FAIL wd_drop req=%b pend=%b want 0/010010", bus.irq_req, bus.pend); end
        cyc('0, '0, '0, 0);
        total++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd1) begin bad++;
            $display("FAIL wd_next req=%b id=%0d want 1/1", bus.irq_req, bus.irq_id); end
        en = '1;
    endtask

    task automatic test_masked();
        do_reset();
        en = '0;
        cyc(6'b111111, '0, '0, 0);
        repeat (3) cyc('0, '0, '0, 0);
        total++; if (bus.pend !== 6'b111111 || bus.irq_req !== 1'b0) begin bad++;
            $display("FAIL masked pend=%b req=%b want 111111/0", bus.pend, bus.irq_req); end
        en = 6'b100000;
        for (int k = 0; k < 2 && bus.irq_req !== 1'b1; k++) cyc('0, '0, '0, 0);
        total++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd5) begin bad++;
            $display("FAIL unmask req=%b id=%0d want 1/5", bus.irq_req, bus.irq_id); end
    endtask

    task automatic test_random();
        logic [N-1:0] evt, pclr, oclr;
        logic ack;
        do_reset();
        en = '1;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) en = N'($urandom);
            evt  = ($urandom_range(0, 2) == 0) ? (N'($urandom) & N'($urandom)) : '0;
            pclr = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            oclr = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
            ack  = bus.irq_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            cyc(evt, pclr, oclr, ack);
            total++; if (bus.irq_req !== m_req) begin bad++;
                $display("FAIL rnd_req c=%0d got=%b want=%b", c, bus.irq_req, m_req); end
            total++; if (bus.irq_id !== 3'(m_id)) begin bad++;
                $display("FAIL rnd_id c=%0d got=%0d want=%0d", c, bus.irq_id, m_id); end
            total++; if (bus.pend !== m_pend) begin bad++;
                $display("FAIL rnd_pend c=%0d got=%b want=%b", c, bus.pend, m_pend); end
            total++; if (bus.ovrn !== m_ovrn) begin bad++;
                $display("FAIL rnd_ovrn c=%0d got=%b want=%b", c, bus.ovrn, m_ovrn); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_round_robin();
        test_overrun();
        test_withdraw();
        test_masked();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end
endmodule
